conv_window_gen: RTL and testbench

//  Streaming producer for the conv datapath. Accepts a raster-scan pixel stream
//  (one 32-bit word per beat) and builds SIZE x SIZE sliding windows with a line buffer.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_window_gen_line_buffer.sv | 40 ++++
 rtl/conv_window_gen.sv | 125 ++++++++++++
 tb/tb_conv_window_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared word type, window FSM states and window index helper
package conv_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {
      ST_PRIME,
      ST_ACTIVE
   } win_state_e;

   function automatic int win_idx(input int r, input int c, input int size);
      return r * size + c;
   endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// rtl/conv_window_gen_line_buffer.sv - cascaded line buffer, row 0 holds the oldest image row
module conv_window_gen_line_buffer
   import conv_pkg::*;
#(
   parameter int ROWS  = 6,
   parameter int IMG_W = 32
) (
   input  logic                             clk,
   input  logic                             wr_en,
   input  logic [$clog2(IMG_W)-1:0]         col,
   input  logic [DATA_W-1:0]                wr_data,
   output logic [ROWS-1:0][DATA_W-1:0]      taps
);

   // Storage is deliberately unreset; the window is fully refilled before it is emitted.
   word_t mem_q [ROWS][IMG_W];
   word_t mem_d [ROWS][IMG_W];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         for (int r = 0; r < ROWS - 1; r++) begin
            mem_d[r][col] = mem_q[r+1][col];
         end
         mem_d[ROWS-1][col] = wr_data;
      end
   end

   always_comb begin
      taps = '0;
      for (int r = 0; r < ROWS; r++) begin
         taps[r] = mem_q[r][col];
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to SIZE x SIZE sliding window stream
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int SIZE  = 7,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_W-1:0]                 in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [SIZE*SIZE-1:0][DATA_W-1:0]  win_data,
   output logic                              win_valid,
   input  logic                              win_ready,
   output logic                              frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_EMIT  = CW'(SIZE - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_PRIME = RW'(SIZE - 2);

   logic [CW-1:0]                     col_q, col_d;
   logic [RW-1:0]                     row_q, row_d;
   win_state_e                        state_q, state_d;
   logic [SIZE*SIZE-1:0][DATA_W-1:0]  win_q, win_d;
   logic                              win_valid_q, win_valid_d;
   logic                              frame_done_q, frame_done_d;
   logic [SIZE-2:0][DATA_W-1:0]       taps;
   logic                              beat, col_end, frame_end, emit;

   assign in_ready  = ~rst & (~win_valid_q | win_ready);
   assign beat      = in_valid & in_ready;
   assign col_end   = (col_q == COL_LAST);
   assign frame_end = col_end & (row_q == ROW_LAST);
   // ACTIVE covers exactly rows SIZE-1 and below, so only the column gate is left.
   assign emit      = beat & (state_q == ST_ACTIVE) & (col_q >= COL_EMIT);

   conv_window_gen_line_buffer #(
      .ROWS  (SIZE - 1),
      .IMG_W (IMG_W)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (beat),
      .col     (col_q),
      .wr_data (in_data),
      .taps    (taps)
   );

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_valid_d  = win_valid_q;
      frame_done_d = 1'b0;
      if (win_ready) begin
         win_valid_d = 1'b0;
      end
      if (beat) begin
         for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE - 1; c++) begin
               win_d[win_idx(r, c, SIZE)] = win_q[win_idx(r, c + 1, SIZE)];
            end
         end
         for (int r = 0; r < SIZE - 1; r++) begin
            win_d[win_idx(r, SIZE - 1, SIZE)] = taps[r];
         end
         win_d[win_idx(SIZE - 1, SIZE - 1, SIZE)] = in_data;
         if (col_end) begin
            col_d = '0;
            row_d = frame_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         frame_done_d = frame_end;
         if (emit) begin
            win_valid_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PRIME: begin
            if (beat && col_end && (row_q == ROW_PRIME)) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (beat && frame_end) begin
               state_d = ST_PRIME;
            end
         end
         default: state_d = ST_PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         state_q      <= ST_PRIME;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         state_q      <= state_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign win_data   = win_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
module tb_conv_window_gen;

   localparam int S    = 3;
   localparam int W    = 8;
   localparam int H    = 8;
   localparam int NP   = W * H;
   localparam int NWIN = (W - S + 1) * (H - S + 1);

   typedef logic [S*S-1:0][31:0] win_t;

   typedef struct {
      int   vpct;
      int   rpct;
      bit   rnd;
      int   bp_win;
      int   bp_len;
      int   pre_rst;
      bit   chk_ends;
      bit   chk_tags;
      int   exp_cnt;
      int   exp_fd;
      win_t exp_first;
      win_t exp_last;
   } scen_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   win_t        win_data;
   logic        win_valid;
   logic        win_ready = 1'b0;
   logic        frame_done;

   logic                     d_rst = 1'b1;
   logic [31:0]              d_in_data = '0;
   logic                     d_in_valid = 1'b0;
   logic                     d_in_ready;
   logic [48:0][31:0]        d_win_data;
   logic                     d_win_valid;
   logic                     d_win_ready = 1'b1;
   logic                     d_frame_done;

   conv_window_gen #(.SIZE(S), .IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .frame_done (frame_done)
   );

   conv_window_gen dut7 (
      .clk        (clk),
      .rst        (d_rst),
      .in_data    (d_in_data),
      .in_valid   (d_in_valid),
      .in_ready   (d_in_ready),
      .win_data   (d_win_data),
      .win_valid  (d_win_valid),
      .win_ready  (d_win_ready),
      .frame_done (d_frame_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_win(input string name, input win_t act, input win_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: the whole image, and every valid window cut from it in raster order.
   logic [31:0] pix [NP];
   win_t        exp_q [$];

   task automatic build_expected();
      win_t w;
      exp_q.delete();
      for (int r0 = 0; r0 <= H - S; r0++) begin
         for (int c0 = 0; c0 <= W - S; c0++) begin
            for (int r = 0; r < S; r++) begin
               for (int c = 0; c < S; c++) begin
                  w[r*S+c] = pix[(r0 + r) * W + c0 + c];
               end
            end
            exp_q.push_back(w);
         end
      end
   endtask

   int   cyc = 0;
   int   mon_k, last_beat_pix, last_beat_cyc, got_cnt, new_cnt, lat_err, fd_cnt;
   bit   prev_beat_last, prev_valid, prev_ready;
   win_t prev_data, first_win, last_win;
   int   emit_pix [64];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            mon_k = 0; last_beat_pix = -1; last_beat_cyc = -10;
            got_cnt = 0; new_cnt = 0; lat_err = 0; fd_cnt = 0;
            prev_beat_last = 0; prev_valid = 0; prev_ready = 0;
         end else begin
            check("frame_done_timing", frame_done, prev_beat_last);
            if (frame_done) fd_cnt++;
            check("in_ready_rule", in_ready, !win_valid || win_ready);
            if (prev_valid && !prev_ready) begin
               check("hold_valid", win_valid, 1);
               check_win("hold_data", win_data, prev_data);
            end else if (win_valid) begin
               if (new_cnt < 64) emit_pix[new_cnt] = last_beat_pix;
               new_cnt++;
               if (cyc - last_beat_cyc != 1) lat_err++;
            end
            if (win_valid && win_ready) begin
               if (got_cnt >= exp_q.size()) begin
                  check("window_overflow", got_cnt, exp_q.size());
               end else begin
                  check_win($sformatf("window_%0d", got_cnt), win_data, exp_q[got_cnt]);
               end
               if (got_cnt == 0) first_win = win_data;
               last_win = win_data;
               got_cnt++;
            end
            prev_beat_last = 0;
            if (in_valid && in_ready) begin
               last_beat_pix  = mon_k;
               last_beat_cyc  = cyc;
               prev_beat_last = (mon_k == NP - 1);
               mon_k          = (mon_k + 1) % NP;
            end
            prev_valid = win_valid;
            prev_ready = win_ready;
            prev_data  = win_data;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_win_valid", win_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check_win("rst_win_data", win_data, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_pixels(input int npix, input int vpct, input int rpct,
                             input int bp_win, input int bp_len);
      int k = 0;
      int guard = 0;
      int hold = bp_len;
      bit holding;
      while (k < npix && guard < 5000) begin
         in_valid  = ($urandom_range(99) < vpct);
         in_data   = in_valid ? pix[k] : $urandom;
         win_ready = ($urandom_range(99) < rpct);
         holding   = (bp_win >= 0) && (hold > 0) && win_valid && (got_cnt == bp_win);
         if (holding) win_ready = 1'b0;
         @(negedge clk);
         if (holding) begin
            check("bp_in_ready", in_ready, 0);
            hold--;
         end
         if (in_valid && in_ready) k++;
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      check("pixels_accepted", k, npix);
   endtask

   task automatic drain(input int rpct);
      int guard = 0;
      in_valid = 1'b0;
      while ((got_cnt < exp_q.size() || win_valid) && guard < 2000) begin
         win_ready = ($urandom_range(99) < rpct) || (guard > 200);
         @(posedge clk); #1;
         guard++;
      end
      win_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   scen_t tbl [6];
   win_t  w_first, w_last;

   initial begin
      w_first = {32'd18, 32'd17, 32'd16, 32'd10, 32'd9, 32'd8, 32'd2, 32'd1, 32'd0};
      w_last  = {32'd63, 32'd62, 32'd61, 32'd55, 32'd54, 32'd53, 32'd47, 32'd46, 32'd45};
      tbl[0] = '{vpct:100, rpct:100, rnd:0, bp_win:-1, bp_len:0, pre_rst:0, chk_ends:1, chk_tags:1,
                 exp_cnt:NWIN, exp_fd:1, exp_first:w_first, exp_last:w_last};
      tbl[1] = '{vpct:100, rpct:100, rnd:0, bp_win:1, bp_len:5, pre_rst:0, chk_ends:1, chk_tags:0,
                 exp_cnt:NWIN, exp_fd:1, exp_first:w_first, exp_last:w_last};
      tbl[2] = '{vpct:30, rpct:100, rnd:0, bp_win:-1, bp_len:0, pre_rst:0, chk_ends:1, chk_tags:0,
                 exp_cnt:NWIN, exp_fd:1, exp_first:w_first, exp_last:w_last};
      tbl[3] = '{vpct:60, rpct:50, rnd:1, bp_win:-1, bp_len:0, pre_rst:0, chk_ends:0, chk_tags:0,
                 exp_cnt:NWIN, exp_fd:1, exp_first:'0, exp_last:'0};
      tbl[4] = '{vpct:100, rpct:100, rnd:0, bp_win:-1, bp_len:0, pre_rst:21, chk_ends:1, chk_tags:1,
                 exp_cnt:NWIN, exp_fd:1, exp_first:w_first, exp_last:w_last};
      tbl[5] = '{vpct:45, rpct:70, rnd:1, bp_win:10, bp_len:3, pre_rst:0, chk_ends:0, chk_tags:0,
                 exp_cnt:NWIN, exp_fd:1, exp_first:'0, exp_last:'0};

      for (int i = 0; i < 6; i++) begin
         for (int p = 0; p < NP; p++) pix[p] = tbl[i].rnd ? $urandom : 32'(p);
         build_expected();
         do_reset();
         if (tbl[i].pre_rst > 0) begin
            run_pixels(tbl[i].pre_rst, tbl[i].vpct, tbl[i].rpct, -1, 0);
            do_reset();
            check("no_stale_window", win_valid, 0);
         end
         run_pixels(NP, tbl[i].vpct, tbl[i].rpct, tbl[i].bp_win, tbl[i].bp_len);
         drain(tbl[i].rpct);
         check($sformatf("s%0d_window_count", i), got_cnt, tbl[i].exp_cnt);
         check($sformatf("s%0d_frame_done_count", i), fd_cnt, tbl[i].exp_fd);
         check($sformatf("s%0d_latency_errors", i), lat_err, 0);
         if (tbl[i].chk_ends) begin
            check_win($sformatf("s%0d_first_window", i), first_win, tbl[i].exp_first);
            check_win($sformatf("s%0d_last_window", i), last_win, tbl[i].exp_last);
         end
         if (tbl[i].chk_tags) begin
            check($sformatf("s%0d_first_emit_pixel", i), emit_pix[0], 18);
            check($sformatf("s%0d_emit_before_wrap", i), emit_pix[5], 23);
            check($sformatf("s%0d_emit_after_wrap", i), emit_pix[6], 26);
         end
      end

      begin
         int k = 0;
         int nw = 0;
         int guard = 0;
         bit fd = 0;
         logic [31:0] e48_first = '0;
         logic [31:0] e0_last = '0;
         logic [31:0] e48_last = '0;
         d_rst = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         d_rst = 1'b0;
         while ((k < 1024 || d_win_valid) && guard < 3000) begin
            d_in_valid = (k < 1024);
            d_in_data  = 32'(k);
            @(negedge clk);
            if (d_win_valid) begin
               if (nw == 0) e48_first = d_win_data[48];
               e0_last  = d_win_data[0];
               e48_last = d_win_data[48];
               nw++;
            end
            if (d_frame_done) fd = 1;
            if (d_in_valid && d_in_ready) k++;
            @(posedge clk); #1;
            guard++;
         end
         d_in_valid = 1'b0;
         check("size7_window_count", nw, 676);
         check("size7_first_elem48", e48_first, 198);
         check("size7_last_elem0", e0_last, 825);
         check("size7_last_elem48", e48_last, 1023);
         check("size7_frame_done", fd, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
